lsu_seq: RTL

- Load/store initiator between the RV32I core datapath and the byte-addressable data memory port (clk, we, a, wd, MemSize 000=SB/001=SH/010=SW, word-aligned combinational read rd).
- Aligned accesses complete in the request cycle.
- Misaligned LH/LHU/LW/SH/SW are split into a byte-serial sequence; the core is stalled with busy until done.
- Loads are sign- or zero-extended to 32 bits per funct3.

---
 rtl/lsu_seq_if.sv | 31 +++
 rtl/lsu_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lsu_seq_if.sv
// Core/data-memory bus bundle for the load/store sequencer.
// slave modport: the sequencer (takes requests and mem_rd, drives busy/resp/mem strobes).
// master modport: the core plus memory side (drives requests and mem_rd).
interface lsu_seq_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [2:0]  mem_size;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output busy, resp_valid, resp_rdata, resp_err,
        output mem_we, mem_a, mem_wd, mem_size
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  busy, resp_valid, resp_rdata, resp_err,
        input  mem_we, mem_a, mem_wd, mem_size
    );
endinterface

// File: rtl/lsu_seq.sv
// Load/store initiator: aligned accesses go straight to dmem, misaligned ones are split into byte accesses.
// Latency: aligned/illegal respond combinationally in the request cycle; misaligned N-byte access is N busy cycles + 1 DONE cycle.
// Backpressure: busy stalls the core, which holds the request stable until resp_valid.
// Ports: clk, reset (sync, active-high), bus (lsu_seq_if.slave: req_*, busy, resp_*, mem_*).
module lsu_seq #(
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    lsu_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPLIT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic [31:0] acc, acc_nxt;

    logic        busy, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_a, mem_wd;
    logic [2:0]  mem_size;

    logic        legal, aligned;
    logic [1:0]  last_idx;
    logic [31:0] byte_addr;
    logic [7:0]  rd_byte, wd_byte;
    logic [31:0] rd_shift;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  extend = {{24{d[7]}}, d[7:0]};
            3'b001:  extend = {{16{d[15]}}, d[15:0]};
            3'b100:  extend = {24'd0, d[7:0]};
            3'b101:  extend = {16'd0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    // Request decode and byte-lane steering.
    always_comb begin
        legal = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !bus.req_we;
            default:                legal = 1'b0;
        endcase

        aligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !bus.req_addr[0];
            2'b10:   aligned = (bus.req_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase

        // Index of the final byte of a split H or W access.
        last_idx  = bus.req_funct3[1] ? 2'd3 : 2'd1;
        // cnt is 0 in IDLE, so byte 0 uses the same path as the SPLIT bytes.
        byte_addr = bus.req_addr + {30'd0, cnt};
        rd_byte   = bus.mem_rd[{byte_addr[1:0], 3'b000} +: 8];
        wd_byte   = bus.req_wdata[{cnt, 3'b000} +: 8];
        // Bring the addressed byte/half down to bit 0 for aligned loads.
        rd_shift  = bus.mem_rd >> {bus.req_addr[1:0], 3'b000};
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        acc_nxt    = acc;
        busy       = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        mem_we     = 1'b0;
        mem_a      = bus.req_addr;
        mem_wd     = 32'd0;
        mem_size   = 3'b000;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!legal || (!aligned && !MISALIGN_EN)) begin
                        resp_valid = 1'b1;
                        resp_err   = 1'b1;
                    end else if (aligned) begin
                        mem_size   = {1'b0, bus.req_funct3[1:0]};
                        mem_we     = bus.req_we;
                        mem_wd     = bus.req_wdata;
                        resp_valid = 1'b1;
                        if (!bus.req_we) begin
                            resp_rdata = extend(bus.req_funct3, rd_shift);
                        end
                    end else begin
                        busy   = 1'b1;
                        mem_a  = byte_addr;
                        mem_we = bus.req_we;
                        mem_wd = {24'd0, wd_byte};
                        if (!bus.req_we) begin
                            acc_nxt[7:0] = rd_byte;
                        end
                        cnt_nxt   = 2'd1;
                        state_nxt = SPLIT;
                    end
                end
            end
            SPLIT: begin
                busy   = 1'b1;
                mem_a  = byte_addr;
                mem_we = bus.req_we;
                mem_wd = {24'd0, wd_byte};
                if (!bus.req_we) begin
                    acc_nxt[{cnt, 3'b000} +: 8] = rd_byte;
                end
                cnt_nxt = cnt + 2'd1;
                if (cnt == last_idx) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                if (!bus.req_we) begin
                    resp_rdata = extend(bus.req_funct3, acc);
                end
                cnt_nxt   = 2'd0;
                acc_nxt   = 32'd0;
                state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = 2'd0;
                acc_nxt   = 32'd0;
                state_nxt = IDLE;
            end
        endcase

        // Reset suppresses every side effect, including a write in flight.
        if (reset) begin
            busy       = 1'b0;
            resp_valid = 1'b0;
            resp_err   = 1'b0;
            resp_rdata = 32'd0;
            mem_we     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
            acc   <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
        end
    end

    assign bus.busy       = busy;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_err   = resp_err;
    assign bus.resp_rdata = resp_rdata;
    assign bus.mem_we     = mem_we;
    assign bus.mem_a      = mem_a;
    assign bus.mem_wd     = mem_wd;
    assign bus.mem_size   = mem_size;
endmodule
